// File: rtl/wb_result_select.sv
// rtl/wb_result_select.sv - write-back source select with load handshake and byte/halfword extraction
// Issues a word read for loads, then drives one registered register-file write per instruction.
module wb_result_select #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  rd,
  input  logic        reg_wr_en,
  input  logic [1:0]  wb_sel,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy,
  output logic        done,
  output logic        load_err
);

  typedef enum logic [1:0] {IDLE, MEMWAIT, WRITE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        fin, fin_err, fin_we;
  logic [4:0]  fin_rd;
  logic [31:0] fin_data;
  logic        f3_legal, misaligned;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  always_comb begin
    f3_legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                 ((funct3 == 3'b010) && (alu_result[1:0] != 2'b00));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    we_d     = we_q;
    f3_d     = f3_q;
    lo_d     = lo_q;
    addr_d   = addr_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rf_we_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_we   = 1'b0;
    fin_rd   = rd_q;
    fin_data = 32'd0;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (start) begin
          rd_d   = rd;
          we_d   = reg_wr_en;
          f3_d   = funct3;
          lo_d   = alu_result[1:0];
          addr_d = {alu_result[31:2], 2'b00};
          fin_we = reg_wr_en;
          fin_rd = rd;
          case (wb_sel)
            2'b00:   fin_data = alu_result;
            2'b10:   fin_data = pc + 32'd4;
            2'b11:   fin_data = imm;
            default: fin_data = 32'd0;
          endcase
          if (wb_sel != 2'b01) begin
            fin = 1'b1;
          end else if (!f3_legal || misaligned) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_d = MEMWAIT;
          end
        end
      end
      MEMWAIT: begin
        fin_we = we_q;
        // Data arriving on the last counted cycle still wins over the timeout.
        if (mem_rvalid) begin
          fin      = 1'b1;
          fin_data = load_ext(f3_q, lo_q, mem_rdata);
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d = WRITE;
      done_d  = 1'b1;
      err_d   = fin_err;
      rf_we_d = fin_we && (fin_rd != 5'd0) && !fin_err;
      waddr_d = fin_rd;
      wdata_d = fin_err ? 32'd0 : fin_data;
    end

    req_d  = (state_d == MEMWAIT);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rd_q    <= 5'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      lo_q    <= 2'd0;
      addr_q  <= 32'd0;
      req_q   <= 1'b0;
      rf_we_q <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      rf_we_q <= rf_we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_wb_result_select.sv
// tb/tb_wb_result_select.sv - table-driven scoreboard bench for wb_result_select
module tb_wb_result_select;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  rd = '0;
  logic        reg_wr_en = 1'b0;
  logic [1:0]  wb_sel = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] alu_result = '0, pc = '0, imm = '0, mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_req, rf_we, busy, done, load_err;
  logic [31:0] mem_addr, rf_wdata;
  logic [4:0]  rf_waddr;

  wb_result_select #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .rd(rd), .reg_wr_en(reg_wr_en),
    .wb_sel(wb_sel), .funct3(funct3), .alu_result(alu_result), .pc(pc), .imm(imm),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_req(mem_req),
    .mem_addr(mem_addr), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // dly: -2 no memory access expected, -1 never respond, else cycles after mem_req rises
  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] alu, pc, imm;
    int          dly;
    logic [31:0] exp_data;
    logic        exp_we, exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        we, err;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vt[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("rf_wdata", rf_wdata, mon_e.data);
          chk("rf_we", {31'd0, rf_we}, {31'd0, mon_e.we});
          chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, mon_e.rd});
          chk("load_err", {31'd0, load_err}, {31'd0, mon_e.err});
          chk("busy_at_done", {31'd0, busy}, 32'd1);
          chk("done_cycle", cyc, mon_e.cyc);
        end
      end else begin
        chk("strobes_idle", {30'd0, rf_we, load_err}, 32'd0);
      end
    end
  end

  function automatic vec_t mk(logic [1:0] sel, logic [2:0] f3, logic [4:0] r, logic we,
                              logic [31:0] alu, logic [31:0] p, logic [31:0] im, int dly,
                              logic [31:0] ed, logic ewe, logic eerr, int lat);
    vec_t v;
    v.sel = sel; v.f3 = f3; v.rd = r; v.we = we; v.alu = alu; v.pc = p; v.imm = im;
    v.dly = dly; v.exp_data = ed; v.exp_we = ewe; v.exp_err = eerr; v.exp_lat = lat;
    return v;
  endfunction

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_wait: got busy=1 after 40 cycles expected busy=0");
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    @(negedge clk);
    wb_sel = v.sel; funct3 = v.f3; rd = v.rd; reg_wr_en = v.we;
    alu_result = v.alu; pc = v.pc; imm = v.imm; mem_rdata = 32'h80F17F02;
    start = 1'b1;
    e.data = v.exp_data; e.we = v.exp_we; e.err = v.exp_err; e.rd = v.rd;
    e.cyc = cyc + v.exp_lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (v.dly == -2) begin
      chk("no_mem_req", {31'd0, mem_req}, 32'd0);
    end else begin
      chk("mem_req", {31'd0, mem_req}, 32'd1);
      chk("mem_addr", mem_addr, {v.alu[31:2], 2'b00});
      if (v.dly >= 0) begin
        repeat (v.dly) @(negedge clk);
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end
    wait_idle();
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vt.push_back(mk(2'b00, 3'b000, 5,  1, 32'h12345678, 0, 0, -2, 32'h12345678, 1, 0, 1));
    vt.push_back(mk(2'b10, 3'b000, 1,  1, 0, 32'hFFFFFFFC, 0, -2, 32'h00000000, 1, 0, 1));
    vt.push_back(mk(2'b10, 3'b000, 6,  1, 0, 32'h00001000, 0, -2, 32'h00001004, 1, 0, 1));
    vt.push_back(mk(2'b11, 3'b000, 2,  1, 0, 0, 32'hABCDE000, -2, 32'hABCDE000, 1, 0, 1));
    vt.push_back(mk(2'b01, 3'b000, 3,  1, 32'h103, 0, 0, 3, 32'hFFFFFF80, 1, 0, 5));
    vt.push_back(mk(2'b01, 3'b100, 4,  1, 32'h101, 0, 0, 3, 32'h0000007F, 1, 0, 5));
    vt.push_back(mk(2'b01, 3'b001, 8,  1, 32'h102, 0, 0, 3, 32'hFFFF80F1, 1, 0, 5));
    vt.push_back(mk(2'b01, 3'b010, 9,  1, 32'h100, 0, 0, 3, 32'h80F17F02, 1, 0, 5));
    vt.push_back(mk(2'b01, 3'b101, 10, 1, 32'h100, 0, 0, 3, 32'h00007F02, 1, 0, 5));
    vt.push_back(mk(2'b01, 3'b000, 11, 1, 32'h102, 0, 0, 3, 32'hFFFFFFF1, 1, 0, 5));
    vt.push_back(mk(2'b01, 3'b001, 12, 1, 32'h100, 0, 0, 0, 32'h00007F02, 1, 0, 2));
    vt.push_back(mk(2'b01, 3'b100, 13, 1, 32'h103, 0, 0, 3, 32'h00000080, 1, 0, 5));
    vt.push_back(mk(2'b01, 3'b010, 14, 1, 32'h102, 0, 0, -2, 32'h00000000, 0, 1, 1));
    vt.push_back(mk(2'b01, 3'b011, 15, 1, 32'h100, 0, 0, -2, 32'h00000000, 0, 1, 1));
    vt.push_back(mk(2'b01, 3'b101, 16, 1, 32'h101, 0, 0, -2, 32'h00000000, 0, 1, 1));
    vt.push_back(mk(2'b00, 3'b000, 0,  1, 32'h0000DEAD, 0, 0, -2, 32'h0000DEAD, 0, 0, 1));
    vt.push_back(mk(2'b00, 3'b000, 17, 0, 32'h0000BEEF, 0, 0, -2, 32'h0000BEEF, 0, 0, 1));
    vt.push_back(mk(2'b01, 3'b010, 18, 1, 32'h200, 0, 0, 15, 32'h80F17F02, 1, 0, 17));
    vt.push_back(mk(2'b01, 3'b010, 19, 1, 32'h300, 0, 0, -1, 32'h00000000, 0, 1, 17));

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_outs", {29'd0, rf_we, load_err, |rf_waddr}, 32'd0);
    rst = 1'b0;

    foreach (vt[i]) begin
      run_vec(vt[i]);
      if (vt[i].dly == -1) begin
        @(negedge clk);
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stray_rvalid_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        chk("stray_rvalid_done", {31'd0, done}, 32'd0);
      end
    end

    // Asynchronous reset while waiting on memory.
    @(negedge clk);
    wb_sel = 2'b01; funct3 = 3'b010; rd = 5'd20; reg_wr_en = 1'b1; alu_result = 32'h400;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Start pulse while busy must not issue a second instruction.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("memwait_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    wb_sel = 2'b00; rd = 5'd7; reg_wr_en = 1'b1; alu_result = 32'h00000055;
    start = 1'b1;
    mon_e.data = 32'h00000055; mon_e.we = 1'b1; mon_e.err = 1'b0; mon_e.rd = 5'd7;
    mon_e.cyc = cyc + 1;
    sb.push_back(mon_e);
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_drained", sb.size(), 32'd0);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_result_select.md
Name: wb_result_select

Overview:
- Write-back end of the datapath: the consumer of the ALU result, sitting opposite the ALU operand-select stage.
- Captures the result of an issued instruction and selects the write-back source: ALU result, load data, PC+4 or immediate.
- For loads, performs a word-read handshake with data memory, then extracts and extends the addressed byte or halfword.
- Drives a single register-file write port and reports busy/done to the control unit.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for mem_rvalid before aborting a load (range 2..255).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle issue pulse; sampled only in IDLE
- rd  input  5  destination register index
- reg_wr_en  input  1  instruction writes rd
- wb_sel  input  2  write-back source: 00 ALU, 01 load, 10 PC+4, 11 imm
- funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; others illegal
- alu_result  input  32  ALU output; the load byte address when wb_sel=01
- pc  input  32  PC of the instruction
- imm  input  32  immediate (lui)
- mem_rdata  input  32  read data word
- mem_rvalid  input  1  read data valid, one cycle
- mem_req  output  1  read request, held until the response arrives
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- rf_we  output  1  register-file write enable, one-cycle pulse
- rf_waddr  output  5  register-file write index
- rf_wdata  output  32  register-file write data
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle completion pulse
- load_err  output  1  one-cycle pulse with done: misaligned, illegal funct3 or timeout

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counter=0. All outputs and captured registers are 0.
- States: IDLE, MEMWAIT, WRITE.
- IDLE, start=1:
  - Capture rd, reg_wr_en, wb_sel, funct3, alu_result, pc, imm.
  - wb_sel≠01: go to WRITE.
  - wb_sel=01 and access legal: go to MEMWAIT.
  - wb_sel=01 and access misaligned or illegal: go to WRITE with an error flag set.
  - Misaligned means: lh/lhu with addr[0]=1, or lw with addr[1:0]≠0.
- MEMWAIT:
  - mem_req=1 and mem_addr stable for the whole state.
  - Counter increments each cycle.
  - mem_rvalid=1: capture mem_rdata, go to WRITE.
  - Counter reaches TIMEOUT-1 without mem_rvalid: go to WRITE with the error flag set.
- WRITE (exactly one cycle), then IDLE:
  - done=1 and rf_waddr=rd.
  - rf_we = reg_wr_en & (rd≠0) & ~error.
  - load_err=error.
- Write data by source:
  - 00: alu_result.
  - 10: pc+4 (32-bit, wraps modulo 2^32).
  - 11: imm.
  - 01: byte lane selected by addr[1:0] (lane 0 = bits 7:0); halfword selected by addr[1] (0 = bits 15:0).
    - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
  - On error: rf_wdata=0.
- Latency from start:
  - Non-load or error: done at cycle +1.
  - Load: done one cycle after mem_rvalid.
  - Timeout: done TIMEOUT+1 cycles after start.
- busy=1 from the cycle after start until done, inclusive.
- Ignored inputs: start while busy; mem_rvalid outside MEMWAIT.
- Simultaneous events: mem_rvalid in the same cycle the counter reaches TIMEOUT-1 counts as success (data wins).
- Outputs are registered. rf_wdata and rf_waddr hold their last values outside WRITE; rf_we, done and load_err are 0 outside WRITE.

Test Plan:
- ALU write: start, wb_sel=00, rd=5, alu_result=0x12345678 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, done=1; busy high for that one cycle.
- JAL link: wb_sel=10, pc=0xFFFFFFFC, rd=1 -> rf_wdata=0x00000000 (wraparound); wb_sel=11, imm=0xABCDE000 -> rf_wdata=0xABCDE000.
- Loads with mem_rdata=0x80F17F02, response 3 cycles after mem_req:
  - lb at addr 0x103 -> mem_addr=0x100, rf_wdata=0xFFFFFF80.
  - lbu at addr 0x101 -> 0x0000007F.
  - lh at addr 0x102 -> 0xFFFF80F1.
  - lw -> 0x80F17F02.
  - done one cycle after mem_rvalid in every case.
- Errors:
  - lw at addr 0x102 -> no mem_req, done+load_err at cycle +1, rf_we=0.
  - funct3=011 -> same response.
  - rd=0 with wb_sel=00 -> done=1, rf_we=0.
- Timeout: load issued, mem_rvalid never asserted, TIMEOUT=16 -> mem_req high 16 cycles, then done+load_err, rf_we=0. A mem_rvalid arriving later is ignored.
- Reset in MEMWAIT: assert rst mid-wait -> busy, mem_req and done drop to 0 immediately (asynchronous). After release, start of an ALU op completes normally; start pulses while busy produce no extra done.
